// File: rtl/mult_ctrl_if.sv
// Strobe and handshake bundle between the multiplier sequencer and its accumulator datapath.
// The master side is the sequencer; the slave side is the accumulator owner.
interface mult_ctrl_if;
  logic St;
  logic M;
  logic Load;
  logic Ad;
  logic Sh;
  logic Done;
  logic Busy;

  modport master (
    input  St,
    input  M,
    output Load,
    output Ad,
    output Sh,
    output Done,
    output Busy
  );

  modport slave (
    output St,
    output M,
    input  Load,
    input  Ad,
    input  Sh,
    input  Done,
    input  Busy
  );
endinterface

// File: rtl/mult_ctrl.sv
// Shift-and-add multiplier sequencer: N shift steps, an add before each step whose multiplier
// bit is 1, and a Start/Done handshake toward the datapath owner.
module mult_ctrl #(
  parameter int unsigned N = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  mult_ctrl_if.master bus
);

  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StChk,
    StShift,
    StDone
  } state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic          done_q;
  logic          busy_q;
  logic          load;
  logic          add;
  logic          shift;
  logic          k_last;

  // Strobes are combinational so the accumulator acts in the same cycle as the decision.
  always_comb begin
    load   = (state_q == StIdle) && bus.St && !Rst;
    add    = (state_q == StChk) && bus.M;
    shift  = ((state_q == StChk) && !bus.M) || (state_q == StShift);
    k_last = (k_q == KLast);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          k_q <= '0;
          if (bus.St) begin
            state_q <= StChk;
            busy_q  <= 1'b1;
          end
        end
        StChk: begin
          if (bus.M) begin
            state_q <= StShift;
          end else begin
            k_q <= k_q + KW'(1);
            if (k_last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StShift: begin
          k_q <= k_q + KW'(1);
          if (k_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StChk;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Load = load;
  assign bus.Ad   = add;
  assign bus.Sh   = shift;
  assign bus.Done = done_q;
  assign bus.Busy = busy_q;

endmodule
